seg_scan_ctrl: RTL

Time-multiplexing controller for the board's four-digit seven-segment display. It lets four 4-bit hex values share the single segment bus, each value on its own digit. It sits between the counter datapaths (synchronous/asynchronous up/down counters) and the `led`/`ano` pins, replacing fixed single-digit selection. It owns refresh timing, inter-digit blanking (anti-ghosting), per-digit enable and value capture.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/BCD7.sv | 11 +
 rtl/seg_scan_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// blanking constants and the hex-to-segment table (active-high).
package seg_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_SHOW  = 2'd1,
        ST_OFF   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] ANO_OFF = 4'b1111;

    // Segment order {g,f,e,d,c,b,a}, entry i lights hex digit i.
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/BCD7.sv
// Hex nibble to seven-segment decoder, active-high segments.
module BCD7
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX7[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: cycles through enabled digits,
// with a blanking gap between slots and the digit value captured at slot start.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dig_en,
    output logic [6:0] led,
    output logic [3:0] ano,
    output logic [1:0] dbg_state
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [3:0]    cap;

    logic [2:0]    pick;
    logic [3:0]    sel_val;
    logic          go;
    logic [3:0]    cap_d;
    logic [6:0]    cap_seg;

    // Returns {found, digit}: first enabled digit after cur, wrapping back to cur.
    function automatic logic [2:0] next_digit(input logic [1:0] cur, input logic [3:0] en);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            c = cur + 2'(k);
            if (en[c]) r = {1'b1, c};
        end
        return r;
    endfunction

    assign pick = next_digit(idx, dig_en);

    always_comb begin
        sel_val = d0;
        case (pick[1:0])
            2'd1:    sel_val = d1;
            2'd2:    sel_val = d2;
            2'd3:    sel_val = d3;
            default: sel_val = d0;
        endcase
    end

    // Decoding the capture register's next value lets the segments switch
    // on the same edge as the anode, so the first SHOW cycle is already correct.
    assign go    = (state == ST_BLANK) && (cnt == CW'(BLANK - 1)) && pick[2];
    assign cap_d = go ? sel_val : cap;

    BCD7 u_bcd7 (
        .hex (cap_d),
        .seg (cap_seg)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= 2'd3;
            cap   <= 4'd0;
            ano   <= ANO_OFF;
            led   <= SEG_OFF;
        end else begin
            cap <= cap_d;
            case (state)
                ST_BLANK: begin
                    ano <= ANO_OFF;
                    led <= SEG_OFF;
                    if (cnt == CW'(BLANK - 1)) begin
                        cnt <= '0;
                        if (pick[2]) begin
                            idx   <= pick[1:0];
                            state <= ST_SHOW;
                            ano   <= ~(4'b0001 << pick[1:0]);
                            led   <= ~cap_seg;
                        end else begin
                            state <= ST_OFF;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    ano <= ~(4'b0001 << idx);
                    led <= ~cap_seg;
                    if (cnt == CW'(DIV - 1)) begin
                        cnt   <= '0;
                        state <= ST_BLANK;
                        ano   <= ANO_OFF;
                        led   <= SEG_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OFF: begin
                    ano <= ANO_OFF;
                    led <= SEG_OFF;
                    cnt <= '0;
                    if (dig_en != 4'd0) state <= ST_BLANK;
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                    ano   <= ANO_OFF;
                    led   <= SEG_OFF;
                end
            endcase
        end
    end

endmodule
